// File: rtl/recon_pkg.sv
// Shared types and defaults for the wavelet reconstruction phase scheduler.
// Latency: n/a (package only).
// Backpressure: n/a; provides the state enum, default parameters and timer width helper.
package recon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } recon_state_e;

    localparam int DEF_IN_PERIOD  = 8;
    localparam int DEF_FILL_DEPTH = 3;
    localparam int DEF_PIPE_LAT   = 3;

    // Width of a counter that must hold 0..period inclusive.
    function automatic int recon_tmr_w(input int period);
        return $clog2(period + 1);
    endfunction

endpackage

// File: rtl/recon_emit_timer.sv
// Period timer plus even/odd select decode for one scheduled sample (real or flush-injected).
// Latency: sel_even PIPE_LAT cycles after restart, sel_odd IN_PERIOD/2 cycles later; both registered.
// Backpressure: none; a restart re-times the period and drops any strobe that has not fired yet.
// Ports: restart/arm (sample accepted, schedule strobes), clear (return to idle),
//        expired (timer reached IN_PERIOD), sel_even/sel_odd (registered strobes).
module recon_emit_timer
    import recon_pkg::*;
#(
    parameter int IN_PERIOD = DEF_IN_PERIOD,
    parameter int PIPE_LAT  = DEF_PIPE_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic arm,
    input  logic clear,
    output logic expired,
    output logic sel_even,
    output logic sel_odd
);

    localparam int TW = recon_tmr_w(IN_PERIOD);
    localparam logic [TW-1:0] T_PER  = TW'(IN_PERIOD);
    localparam logic [TW-1:0] T_EVEN = TW'(PIPE_LAT);
    localparam logic [TW-1:0] T_ODD  = TW'(PIPE_LAT + IN_PERIOD / 2);

    // cnt_q holds the number of cycles since the last accepted sample (that cycle counts as 0).
    logic [TW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;

    assign expired = (cnt_q == T_PER);

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (clear) begin
            cnt_d   = '0;
            armed_d = 1'b0;
        end else if (restart) begin
            cnt_d   = TW'(1);
            armed_d = arm;
        end else if (!expired) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Decode on the next-cycle timer value so the strobes come out of flops
    // exactly PIPE_LAT (and PIPE_LAT+IN_PERIOD/2) cycles after the sample.
    // A restart resets cnt_d to 1, which is what cancels pending strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            sel_even <= 1'b0;
            sel_odd  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            sel_even <= armed_d && (cnt_d == T_EVEN);
            sel_odd  <= armed_d && (cnt_d == T_ODD);
        end
    end

endmodule

// File: rtl/recon_phase_sched.sv
// Phase scheduler for one wavelet reconstruction level: shift/select/clear strobes from a sparse din_valid stream.
// Latency: shift_en combinational with din_valid; sel_even PIPE_LAT cycles after an accepted RUN sample.
// Backpressure: none; early samples are accepted and flag period_err, samples during flush are dropped.
// Ports: clk, rst_n (sync, active low), din_valid in; shift_en, zero_sel, sel_even, sel_odd,
//        hist_clr, frame_done, busy, period_err out.
// Build option: define RECON_SCHED_FLUSH_EN to zero-flush the filter tail after a RUN stream stops.
// PIPE_LAT must be at least 1 (strobes are registered) and below IN_PERIOD/2.
module recon_phase_sched
    import recon_pkg::*;
#(
    parameter int IN_PERIOD  = DEF_IN_PERIOD,
    parameter int FILL_DEPTH = DEF_FILL_DEPTH,
    parameter int PIPE_LAT   = DEF_PIPE_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_valid,
    output logic shift_en,
    output logic zero_sel,
    output logic sel_even,
    output logic sel_odd,
    output logic hist_clr,
    output logic frame_done,
    output logic busy,
    output logic period_err
);

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_FILL  = 2'(FILL);
    localparam logic [1:0] S_RUN   = 2'(RUN);
    localparam logic [1:0] S_FLUSH = 2'(FLUSH);
    localparam int         CW      = $clog2(FILL_DEPTH + 2);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;      // fill samples seen, or injections issued in FLUSH
    logic          expired;
    logic          t_restart, t_arm;
    logic          go_idle, inj, perr_set;
    logic          end_q, perr_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        t_restart = 1'b0;
        t_arm     = 1'b0;
        go_idle   = 1'b0;
        inj       = 1'b0;
        perr_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    t_restart = 1'b1;
                    if (FILL_DEPTH == 0) begin
                        state_d = S_RUN;
                        t_arm   = 1'b1;
                    end else begin
                        state_d = S_FILL;
                        cnt_d   = CW'(1);
                    end
                end
            end
            S_FILL: begin
                if (din_valid) begin
                    t_restart = 1'b1;
                    perr_set  = !expired;
                    if (cnt_q == CW'(FILL_DEPTH)) begin
                        // this sample completes the history: it is the first RUN t0
                        state_d = S_RUN;
                        t_arm   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (expired) begin
                    state_d = S_IDLE;
                    go_idle = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (din_valid) begin
                    t_restart = 1'b1;
                    t_arm     = 1'b1;
                    perr_set  = !expired;
                end else if (expired) begin
`ifdef RECON_SCHED_FLUSH_EN
                    if (FILL_DEPTH > 0) begin
                        // the timeout cycle itself carries the first zero injection
                        state_d   = S_FLUSH;
                        inj       = 1'b1;
                        t_restart = 1'b1;
                        t_arm     = 1'b1;
                        cnt_d     = CW'(1);
                    end else begin
                        state_d = S_IDLE;
                        go_idle = 1'b1;
                    end
`else
                    state_d = S_IDLE;
                    go_idle = 1'b1;
`endif
                end
            end
`ifdef RECON_SCHED_FLUSH_EN
            S_FLUSH: begin
                perr_set = din_valid;
                if (expired) begin
                    if (cnt_q == CW'(FILL_DEPTH)) begin
                        state_d = S_IDLE;
                        go_idle = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        inj       = 1'b1;
                        t_restart = 1'b1;
                        t_arm     = 1'b1;
                        cnt_d     = cnt_q + CW'(1);
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    recon_emit_timer #(
        .IN_PERIOD (IN_PERIOD),
        .PIPE_LAT  (PIPE_LAT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (t_restart),
        .arm      (t_arm),
        .clear    (go_idle),
        .expired  (expired),
        .sel_even (sel_even),
        .sel_odd  (sel_odd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            end_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            end_q   <= go_idle;
            perr_q  <= perr_q | perr_set;
        end
    end

    // Real samples are ignored while flushing; shift_en then only carries injections.
    assign shift_en   = rst_n && ((din_valid && (state_q != S_FLUSH)) || inj);
`ifdef RECON_SCHED_FLUSH_EN
    assign zero_sel   = rst_n && inj;
`else
    assign zero_sel   = 1'b0;
`endif
    assign hist_clr   = end_q;
    assign frame_done = end_q;
    assign busy       = (state_q != S_IDLE);
    assign period_err = perr_q;

endmodule

// File: tb/tb_recon_phase_sched.sv
module tb_recon_phase_sched;
    import recon_pkg::*;

    localparam int P   = DEF_IN_PERIOD;
    localparam int FDP = DEF_FILL_DEPTH;
    localparam int PL  = DEF_PIPE_LAT;
    localparam int NC  = 700;

    // output vector bit positions
    localparam logic [7:0] B_SH = 8'h80;
    localparam logic [7:0] B_ZS = 8'h40;
    localparam logic [7:0] B_SE = 8'h20;
    localparam logic [7:0] B_SO = 8'h10;
    localparam logic [7:0] B_HC = 8'h08;
    localparam logic [7:0] B_FD = 8'h04;
    localparam logic [7:0] B_BY = 8'h02;
    localparam logic [7:0] B_PE = 8'h01;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din_valid = 1'b0;
    logic shift_en, zero_sel, sel_even, sel_odd, hist_clr, frame_done, busy, period_err;
    logic [7:0] outv;

    always #5 clk = ~clk;

    recon_phase_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .shift_en   (shift_en),
        .zero_sel   (zero_sel),
        .sel_even   (sel_even),
        .sel_odd    (sel_odd),
        .hist_clr   (hist_clr),
        .frame_done (frame_done),
        .busy       (busy),
        .period_err (period_err)
    );

    assign outv = {shift_en, zero_sel, sel_even, sel_odd, hist_clr, frame_done, busy, period_err};

    typedef struct {
        int         scen;
        int         cyc;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl[$];
    bit         din  [NC];
    logic [7:0] act  [NC];
    logic [7:0] expv [NC];
    int         n_pass = 0;
    int         n_chk  = 0;
    string      snames [6] = '{"stream", "short", "early", "coincident", "flush", "reset"};

    task automatic chk(input string nm, input int c, input logic [7:0] a, input logic [7:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s cycle %0d: got {sh,zs,se,so,hc,fd,by,pe}=%b want %b", nm, c, a, e);
    endtask

    function automatic void add(input int s, input int c, input logic [7:0] e);
        vec_t v;
        v.scen = s; v.cyc = c; v.exp = e;
        tbl.push_back(v);
    endfunction

    function automatic void build_table();
        // 0: ten samples every 8 cycles from 0
        add(0, 0,  B_SH);
        add(0, 1,  B_BY);
        add(0, 8,  B_SH | B_BY);
        add(0, 26, B_BY);
        add(0, 27, B_BY | B_SE);
        add(0, 31, B_BY | B_SO);
        add(0, 32, B_SH | B_BY);
        add(0, 35, B_BY | B_SE);
        add(0, 75, B_BY | B_SE);
        add(0, 79, B_BY | B_SO);
`ifdef RECON_SCHED_FLUSH_EN
        add(0, 80, B_SH | B_ZS | B_BY);
        add(0, 81, B_BY);
`else
        add(0, 80, B_BY);
        add(0, 81, B_HC | B_FD);
        add(0, 82, 8'h00);
`endif
        // 1: two samples only
        add(1, 8,  B_SH | B_BY);
        add(1, 11, B_BY);
        add(1, 15, B_BY);
        add(1, 16, B_BY);
        add(1, 17, B_HC | B_FD);
        add(1, 18, 8'h00);
        // 2: early sample at 29
        add(2, 27, B_BY | B_SE);
        add(2, 29, B_SH | B_BY);
        add(2, 30, B_BY | B_PE);
        add(2, 31, B_BY | B_PE);
        add(2, 32, B_BY | B_PE | B_SE);
        add(2, 36, B_BY | B_PE | B_SO);
`ifndef RECON_SCHED_FLUSH_EN
        add(2, 38, B_HC | B_FD | B_PE);
`endif
        // 3: sample coincident with hist_clr opens a new fill
        add(3, 17, B_SH | B_HC | B_FD);
        add(3, 18, B_BY);
        add(3, 36, B_BY);
        add(3, 43, B_BY);
        add(3, 44, B_BY | B_SE);
        add(3, 48, B_BY | B_SO);
        // 4: flush tail with a dropped sample at 90
        add(4, 80,  B_SH | B_ZS | B_BY);
        add(4, 83,  B_BY | B_SE);
        add(4, 87,  B_BY | B_SO);
        add(4, 88,  B_SH | B_ZS | B_BY);
        add(4, 90,  B_BY);
        add(4, 91,  B_BY | B_SE | B_PE);
        add(4, 95,  B_BY | B_SO | B_PE);
        add(4, 96,  B_SH | B_ZS | B_BY | B_PE);
        add(4, 99,  B_BY | B_SE | B_PE);
        add(4, 103, B_BY | B_SO | B_PE);
        add(4, 104, B_BY | B_PE);
        add(4, 105, B_HC | B_FD | B_PE);
        add(4, 106, B_PE);
        // 5: reset for one cycle (cycle 30) mid-RUN after an error
        add(5, 29, B_SH | B_BY);
        add(5, 30, B_BY | B_PE);
        add(5, 31, 8'h00);
        add(5, 32, B_SH);
        add(5, 33, B_BY);
        add(5, 35, B_BY);
    endfunction

    task automatic setup_scen(input int s);
        for (int c = 0; c < NC; c++) din[c] = 1'b0;
        case (s)
            0: for (int k = 0; k < 10; k++) din[8*k] = 1'b1;
            1: begin din[0] = 1'b1; din[8] = 1'b1; end
            2: begin din[0] = 1'b1; din[8] = 1'b1; din[16] = 1'b1; din[24] = 1'b1; din[29] = 1'b1; end
            3: begin
                din[0] = 1'b1; din[8] = 1'b1;
                din[17] = 1'b1; din[25] = 1'b1; din[33] = 1'b1; din[41] = 1'b1;
            end
            4: begin
                for (int k = 0; k < 10; k++) din[8*k] = 1'b1;
                din[90] = 1'b1;
            end
            default: begin
                din[0] = 1'b1; din[8] = 1'b1; din[16] = 1'b1; din[24] = 1'b1;
                din[29] = 1'b1; din[32] = 1'b1; din[40] = 1'b1;
            end
        endcase
    endtask

    task automatic gen_random();
        int c;
        int r;
        for (int i = 0; i < NC; i++) din[i] = 1'b0;
        c = $urandom_range(0, 5);
        while (c < NC - 120) begin
            din[c] = 1'b1;
            r = $urandom_range(0, 99);
            if (r < 65)      c += P;
            else if (r < 80) c += $urandom_range(1, P - 1);
            else if (r < 90) c += P + 1;
            else             c += $urandom_range(P + 2, 6 * P);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_state", -1, outv, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        din_valid = 1'b0;
    endtask

    task automatic capture(input int rst_cyc);
        do_reset();
        for (int c = 0; c < NC; c++) begin
            rst_n = (c != rst_cyc);
            din_valid = din[c];
            @(negedge clk);
            act[c] = outv;
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        din_valid = 1'b0;
    endtask

    // ---------------- reference model: works on the list of sample times ----------------
    function automatic void mark(input int c, input logic [7:0] m);
        if (c >= 0 && c < NC) expv[c] = expv[c] | m;
    endfunction

    function automatic void unmark(input int c, input logic [7:0] m);
        if (c >= 0 && c < NC) expv[c] = expv[c] & ~m;
    endfunction

    // Stream began at 'start', last accepted sample at 'last', n samples in total.
    task automatic close_stream(input int start, input int last, input int n, output int te);
        te = last + P;
`ifdef RECON_SCHED_FLUSH_EN
        if (n >= FDP + 1) begin
            for (int k = 1; k <= FDP; k++) begin
                mark(last + k*P, B_SH | B_ZS);
                mark(last + k*P + PL, B_SE);
                mark(last + k*P + PL + P/2, B_SO);
            end
            te = last + (FDP + 1) * P;
        end
`endif
        for (int c = start + 1; c <= te; c++) mark(c, B_BY);
        mark(te + 1, B_HC | B_FD);
    endtask

    task automatic build_model();
        int n;
        int start;
        int last;
        int drop_until;
        int te;
        int perr_from;
        n = 0; start = 0; last = 0; drop_until = -1; te = 0; perr_from = NC + 1;
        for (int c = 0; c < NC; c++) expv[c] = 8'h00;
        for (int c = 0; c < NC; c++) begin
            if (!din[c]) continue;
            if (n > 0 && c - last > P) begin
                close_stream(start, last, n, te);
                drop_until = te;
                n = 0;
            end
            if (n == 0 && c <= drop_until) begin
                if (c + 1 < perr_from) perr_from = c + 1;
                continue;
            end
            mark(c, B_SH);
            if (n == 0) begin
                start = c;
                n = 1;
            end else begin
                if (c - last < P && c + 1 < perr_from) perr_from = c + 1;
                if (c < last + PL) unmark(last + PL, B_SE);
                if (c < last + PL + P/2) unmark(last + PL + P/2, B_SO);
                n++;
            end
            if (n >= FDP + 1) begin
                mark(c + PL, B_SE);
                mark(c + PL + P/2, B_SO);
            end
            last = c;
        end
        if (n > 0) close_stream(start, last, n, te);
        for (int c = 0; c < NC; c++) if (c >= perr_from) expv[c] = expv[c] | B_PE;
    endtask

    initial begin
        build_table();
        for (int s = 0; s < 6; s++) begin
`ifndef RECON_SCHED_FLUSH_EN
            if (s == 4) continue;
`endif
            setup_scen(s);
            capture(s == 5 ? 30 : -1);
            foreach (tbl[i]) begin
                if (tbl[i].scen == s) chk(snames[s], tbl[i].cyc, act[tbl[i].cyc], tbl[i].exp);
            end
            if (s != 5) begin
                build_model();
                for (int c = 0; c < NC; c++) chk({snames[s], "_model"}, c, act[c], expv[c]);
            end
        end
        for (int r = 0; r < 6; r++) begin
            gen_random();
            capture(-1);
            build_model();
            for (int c = 0; c < NC; c++) chk("random", c, act[c], expv[c]);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
